// File: rtl/threshold_monitor_pkg.sv
// Shared types and helpers for the threshold monitor.
// Latency: none (types and a constant function only).
// Backpressure: none.
package threshold_monitor_pkg;

  // Alarm FSM states. HI_PEND / LO_PEND are the debounce windows on the way
  // into and out of the alarm condition.
  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    HI_PEND = 2'd1,
    HIGH    = 2'd2,
    LO_PEND = 2'd3
  } state_t;

  // Width of the debounce counter. It must hold values up to DEBOUNCE.
  // The result is at least one bit, so DEBOUNCE==1 still gets a legal vector.
  function automatic int dbnc_cnt_w(input int debounce);
    return (debounce < 1) ? 1 : $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/threshold_cmp.sv
// Stage-1 compare slice: registers the sample-vs-threshold flags, valid and config error.
// Latency: 1 cycle from sample/thresholds to the registered flags.
// Backpressure: none; every cycle is accepted, and invalid cycles only clear valid_d1.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   thresholds    {high, low}, each DATA_W bits
//   sample        sample value; sample_valid qualifies it
//   ge_hi, le_lo  registered sample>=high and sample<=low
//   valid_d1      registered sample_valid
//   cfg_err       registered high<low (updated every cycle, independent of valid)
module threshold_cmp
  import threshold_monitor_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] thresholds,
  input  logic [DATA_W-1:0]   sample,
  input  logic                sample_valid,
  output logic                ge_hi,
  output logic                le_lo,
  output logic                valid_d1,
  output logic                cfg_err
);

  logic [DATA_W-1:0] high;
  logic [DATA_W-1:0] low;

  assign high = thresholds[2*DATA_W-1:DATA_W];
  assign low  = thresholds[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ge_hi    <= 1'b0;
      le_lo    <= 1'b0;
      valid_d1 <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      ge_hi    <= (sample >= high);
      le_lo    <= (sample <= low);
      valid_d1 <= sample_valid;
      // Equal thresholds are legal. Only a strict inversion is an error.
      cfg_err  <= (high < low);
    end
  end

endmodule

// File: rtl/threshold_monitor.sv
// Hysteresis + debounce threshold alarm with a saturating alarm-event counter.
// Latency: 2 cycles from sample to alarm_o/alarm_rise_o; event_cnt_o follows alarm_rise_o by 1 cycle.
// Backpressure: none; invalid cycles hold the FSM and debounce count, so sample gaps are tolerated.
//
// Ports:
//   clk_i, rst_i    clock and synchronous active-high reset
//   thresholds_i    {high[2*DATA_W-1:DATA_W], low[DATA_W-1:0]}
//   sample_i        sample value, qualified by sample_valid_i
//   clear_i         one-cycle pulse that zeroes event_cnt_o; it wins over a same-cycle increment
//   alarm_o         state is HIGH or LO_PEND
//   alarm_rise_o    one-cycle pulse on a fresh entry to HIGH
//   event_cnt_o     number of fresh alarm entries, saturating
//   cfg_err_o       registered high<low
module threshold_monitor
  import threshold_monitor_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2*DATA_W-1:0] thresholds_i,
  input  logic [DATA_W-1:0]   sample_i,
  input  logic                sample_valid_i,
  input  logic                clear_i,
  output logic                alarm_o,
  output logic                alarm_rise_o,
  output logic [CNT_W-1:0]    event_cnt_o,
  output logic                cfg_err_o
);

  localparam int             CW       = dbnc_cnt_w(DEBOUNCE);
  localparam logic [CW-1:0]  DBN_LAST = CW'(DEBOUNCE);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CNT_W-1:0] EV_MAX = '1;

  logic ge_hi;
  logic le_lo;
  logic valid_d1;
  logic cfg_err;

  threshold_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .clk          (clk_i),
    .rst          (rst_i),
    .thresholds   (thresholds_i),
    .sample       (sample_i),
    .sample_valid (sample_valid_i),
    .ge_hi        (ge_hi),
    .le_lo        (le_lo),
    .valid_d1     (valid_d1),
    .cfg_err      (cfg_err)
  );

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [CW-1:0]   cnt_inc;
  logic            rise;
  logic            rise_n;
  logic [CNT_W-1:0] event_cnt;

  assign cnt_inc = cnt + CNT_ONE;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= NORMAL;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rise  <= rise_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rise_n  = 1'b0;
    if (cfg_err) begin
      // An inverted config can't be judged. Park in NORMAL until it is fixed.
      state_n = NORMAL;
      cnt_n   = '0;
    end else if (valid_d1) begin
      unique case (state)
        NORMAL: begin
          if (ge_hi) begin
            if (DEBOUNCE == 1) begin
              state_n = HIGH;
              rise_n  = 1'b1;
            end else begin
              state_n = HI_PEND;
              cnt_n   = CNT_ONE;
            end
          end
        end
        HI_PEND: begin
          if (ge_hi) begin
            if (cnt_inc == DBN_LAST) begin
              state_n = HIGH;
              cnt_n   = '0;
              rise_n  = 1'b1;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = NORMAL;
            cnt_n   = '0;
          end
        end
        HIGH: begin
          if (le_lo) begin
            if (DEBOUNCE == 1) begin
              state_n = NORMAL;
            end else begin
              state_n = LO_PEND;
              cnt_n   = CNT_ONE;
            end
          end
        end
        LO_PEND: begin
          if (le_lo) begin
            if (cnt_inc == DBN_LAST) begin
              state_n = NORMAL;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            // A failed exit debounce drops back into the existing alarm.
            // This is not a new event.
            state_n = HIGH;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = NORMAL;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // The counter counts the registered rise pulse. This lets a clear_i issued
  // in the same cycle as alarm_rise_o discard that increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      event_cnt <= '0;
    end else if (clear_i) begin
      event_cnt <= '0;
    end else if (rise && (event_cnt != EV_MAX)) begin
      event_cnt <= event_cnt + 1'b1;
    end
  end

  assign alarm_o      = (state == HIGH) || (state == LO_PEND);
  assign alarm_rise_o = rise;
  assign event_cnt_o  = event_cnt;
  assign cfg_err_o    = cfg_err;

endmodule

// File: tb/tb_threshold_monitor.sv
// Directed bench for threshold_monitor (DATA_W=16, DEBOUNCE=4, CNT_W=2).
// Latency: inputs are driven 1 time unit after a rising edge; outputs are sampled at that same point.
// Backpressure: n/a.
module tb_threshold_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] thresholds;
  logic [15:0] sample;
  logic        sample_valid;
  logic        clear;
  logic        alarm;
  logic        alarm_rise;
  logic [1:0]  event_cnt;
  logic        cfg_err;

  int total = 0;
  int bad   = 0;

  threshold_monitor #(
    .DATA_W   (16),
    .DEBOUNCE (4),
    .CNT_W    (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .thresholds_i   (thresholds),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .clear_i        (clear),
    .alarm_o        (alarm),
    .alarm_rise_o   (alarm_rise),
    .event_cnt_o    (event_cnt),
    .cfg_err_o      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One valid sample for one cycle. On return, stage 1 has captured it.
  task automatic send(input logic [15:0] s);
    sample       = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send_n(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) send(s);
  endtask

  initial begin
    rst          = 1'b1;
    thresholds   = {16'h0100, 16'h0080};
    sample       = 16'h0000;
    sample_valid = 1'b0;
    clear        = 1'b0;

    // 1. reset
    ticks(3);
    rst = 1'b0;
    chk("rst_alarm", alarm, 0);
    chk("rst_rise", alarm_rise, 0);
    chk("rst_cnt", event_cnt, 0);
    chk("rst_cfg", cfg_err, 0);
    send_n(16'h0000, 3);
    ticks(2);
    chk("zero_alarm", alarm, 0);

    // 2. four samples at exactly high, with 2-cycle gaps
    for (int i = 0; i < 3; i++) begin
      send(16'h0100);
      ticks(2);
    end
    chk("gap_3rd_alarm", alarm, 0);
    send(16'h0100);
    chk("gap_4th_lat1", alarm, 0);
    tick();
    chk("gap_alarm", alarm, 1);
    chk("gap_rise", alarm_rise, 1);
    tick();
    chk("gap_rise_pulse", alarm_rise, 0);
    chk("gap_cnt", event_cnt, 1);

    // 3. a broken debounce restarts the count
    send_n(16'h0000, 4);
    ticks(2);
    chk("t3_normal", alarm, 0);
    send_n(16'h0150, 3);
    send(16'h00FF);
    ticks(2);
    chk("t3_broken", alarm, 0);
    send_n(16'h0150, 3);
    ticks(2);
    chk("t3_three", alarm, 0);
    send(16'h0150);
    tick();
    chk("t3_alarm", alarm, 1);
    chk("t3_rise", alarm_rise, 1);
    tick();
    chk("t3_cnt", event_cnt, 2);

    // 4. hysteresis and exit debounce
    send_n(16'h0081, 10);
    ticks(2);
    chk("t4_hyst", alarm, 1);
    send_n(16'h0080, 3);
    send(16'h0090);
    tick();
    chk("t4_back_high", alarm, 1);
    chk("t4_no_rise", alarm_rise, 0);
    tick();
    chk("t4_cnt_same", event_cnt, 2);
    send_n(16'h0080, 4);
    chk("t4_exit_lat1", alarm, 1);
    tick();
    chk("t4_exit", alarm, 0);
    chk("t4_cnt_exit", event_cnt, 2);

    // 5. inverted thresholds while in HIGH
    send_n(16'h0200, 4);
    tick();
    chk("t5_alarm", alarm, 1);
    tick();
    chk("t5_cnt3", event_cnt, 3);
    thresholds = {16'h0010, 16'h0020};
    tick();
    chk("t5_cfg_set", cfg_err, 1);
    tick();
    chk("t5_forced", alarm, 0);
    thresholds = {16'h0100, 16'h0080};
    tick();
    chk("t5_cfg_clr", cfg_err, 0);
    chk("t5_still_normal", alarm, 0);

    // 6. saturation and clear priority
    send_n(16'h0200, 4);
    tick();
    chk("t6_rise4", alarm_rise, 1);
    tick();
    chk("t6_sat", event_cnt, 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clear", event_cnt, 0);
    send_n(16'h0000, 4);
    ticks(2);
    chk("t6_normal", alarm, 0);
    send_n(16'h0200, 4);
    tick();
    chk("t6_rise5", alarm_rise, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clear_wins", event_cnt, 0);
    send_n(16'h0000, 4);
    ticks(2);
    send_n(16'h0200, 4);
    ticks(2);
    chk("t6_count_again", event_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
